companion_action_ctrl: RTL and testbench
========================================

COMPANION_ACTION_CTRL -- requirements
Module: companion_action_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_250_000, SHALL set the consecutive cycles a synchronized button must differ from its debounced value before the debounced value changes (10 ms at 125 MHz); legal range >=1.
REQ-002 Parameter COOLDOWN_CYCLES, default 125_000_000, SHALL set the cycles spent in COOLDOWN after each issued action (1 s at 125 MHz); legal range >=1.
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low (rst=0 resets on the next rising edge of clk).
REQ-005 btn_feed, btn_play, btn_clean  in  1 each  raw asynchronous push-buttons, high = pressed.
REQ-006 alive  in  1  high when companion health is nonzero.
REQ-007 feed, play, clean_up  out  1 each  registered single-cycle action pulses for the stat block.
REQ-008 busy  out  1  high while the FSM is in FIRE or COOLDOWN.
REQ-009 rejected  out  1  registered single-cycle pulse, high when at least one request was dropped.
REQ-010 last_action  out  2  last issued action: 0 none, 1 feed, 2 clean, 3 play.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL have an independent debounce counter: count up while synchronized value != debounced value, clear to 0 when equal; on the cycle the counter equals DEBOUNCE_CYCLES-1 and values still differ, the debounced value SHALL toggle and the counter clear.
REQ-013 A request SHALL be the rising edge of a debounced value (debounced=1, previous debounced=0), one cycle wide; releases SHALL generate no request.
REQ-014 FSM states SHALL be IDLE, FIRE, COOLDOWN; encoding is implementer's choice.
REQ-015 IDLE: if any request is present and alive=1, SHALL latch the winner by priority feed > clean > play and go to FIRE; else stay IDLE.
REQ-016 FIRE: the winner's output SHALL be high for exactly this one cycle, last_action SHALL update in the same cycle, cooldown counter loads COOLDOWN_CYCLES; next state COOLDOWN.
REQ-017 COOLDOWN: SHALL last exactly COOLDOWN_CYCLES cycles, then IDLE; minimum spacing between successive action pulses is COOLDOWN_CYCLES+2 cycles.
REQ-018 rejected SHALL pulse one cycle after any cycle in which a request was dropped: losers of simultaneous requests in IDLE, any request in FIRE or COOLDOWN, any request in IDLE with alive=0.
REQ-019 Dropped requests SHALL NOT be queued; a held button SHALL NOT retrigger.
REQ-020 Latency: a button held steadily high SHALL produce its pulse beginning DEBOUNCE_CYCLES+3 rising edges after the first edge sampling it high, when the FSM is IDLE and alive=1.
REQ-021 At most one of feed, play, clean_up SHALL be high in any cycle.
REQ-022 alive falling during FIRE or COOLDOWN SHALL NOT cancel the in-progress action or shorten COOLDOWN.

Reset
REQ-023 On rst=0 at a clock edge: state IDLE; feed, play, clean_up, busy, rejected = 0; last_action = 0; synchronizers, debounced values, edge registers, all counters = 0.
REQ-024 Reset mid-FIRE or mid-COOLDOWN SHALL abort immediately with no further pulse; a button still held after reset releases SHALL be debounced afresh and SHALL generate a request.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
REQ-025 btn_feed high from edge 0, alive=1 -> feed high only in the cycle after edge 7, last_action=1, busy high for 9 cycles.
REQ-026 btn_feed high for 3 cycles then low (glitch) -> no pulse, rejected stays 0.
REQ-027 btn_play and btn_clean rise same edge -> clean_up pulses once, play never, rejected pulses once, last_action=2.
REQ-028 btn_play pressed 3 cycles after a feed pulse -> no play pulse, rejected=1 for one cycle, state returns IDLE after 8 COOLDOWN cycles.
REQ-029 alive=0, btn_feed pressed -> no pulse, busy stays 0, rejected pulses once, last_action unchanged.
REQ-030 rst=0 asserted during COOLDOWN with btn_feed still held -> all outputs 0 next cycle; after rst=1, feed pulses DEBOUNCE_CYCLES+3 edges later.

Source files
------------

// File: rtl/companion_action_if.sv
// Handshake bundle between the companion button panel and the action controller.
// Buttons and alive flow into the controller; action pulses and status flow out.
interface companion_action_if;
    logic       btn_feed;
    logic       btn_play;
    logic       btn_clean;
    logic       alive;
    logic       feed;
    logic       play;
    logic       clean_up;
    logic       busy;
    logic       rejected;
    logic [1:0] last_action;

    modport master (
        output btn_feed, btn_play, btn_clean, alive,
        input  feed, play, clean_up, busy, rejected, last_action
    );

    modport slave (
        input  btn_feed, btn_play, btn_clean, alive,
        output feed, play, clean_up, busy, rejected, last_action
    );
endinterface

// File: rtl/companion_action_ctrl.sv
// Debounces three push-buttons and arbitrates them into single-cycle action pulses,
// one at a time, separated by a cooldown window.
module companion_action_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_250_000,
    parameter int COOLDOWN_CYCLES = 125_000_000
) (
    input logic               clk,
    input logic               rst,
    companion_action_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // Button lanes: bit 0 feed, bit 1 clean, bit 2 play (priority order).
    logic [2:0]      btn_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_prev_r;
    logic [DB_W-1:0] db_cnt_r [3];
    logic [2:0]      req_s;

    state_t          state_r;
    logic [1:0]      win_code_s;
    logic            drop_s;
    logic [1:0]      win_r;
    logic [CD_W-1:0] cd_cnt_r;
    logic            feed_r;
    logic            play_r;
    logic            clean_r;
    logic            busy_r;
    logic            rejected_r;
    logic [1:0]      last_action_r;

    assign btn_s = {bus.btn_play, bus.btn_clean, bus.btn_feed};
    assign req_s = deb_r & ~deb_prev_r;

    // Synchronizers, per-button debounce counters and rising-edge history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r    <= 3'b000;
            sync2_r    <= 3'b000;
            deb_r      <= 3'b000;
            deb_prev_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r    <= btn_s;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    deb_r[i]    <= ~deb_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Arbitration: pick the highest-priority request in IDLE and flag anything dropped.
    always_comb begin
        win_code_s = 2'd0;
        drop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.alive) begin
                    if (req_s[0]) begin
                        win_code_s = 2'd1;
                    end else if (req_s[1]) begin
                        win_code_s = 2'd2;
                    end else if (req_s[2]) begin
                        win_code_s = 2'd3;
                    end else begin
                        win_code_s = 2'd0;
                    end
                    drop_s = (req_s[0] & (req_s[1] | req_s[2])) | (req_s[1] & req_s[2]);
                end else begin
                    drop_s = |req_s;
                end
            end
            ST_FIRE, ST_COOLDOWN: begin
                drop_s = |req_s;
            end
            default: begin
                drop_s = |req_s;
            end
        endcase
    end

    // Action FSM with registered pulses, busy and last-action status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            win_r         <= 2'd0;
            cd_cnt_r      <= {CD_W{1'b0}};
            feed_r        <= 1'b0;
            play_r        <= 1'b0;
            clean_r       <= 1'b0;
            busy_r        <= 1'b0;
            rejected_r    <= 1'b0;
            last_action_r <= 2'd0;
        end else begin
            feed_r     <= 1'b0;
            play_r     <= 1'b0;
            clean_r    <= 1'b0;
            rejected_r <= drop_s;
            case (state_r)
                ST_IDLE: begin
                    if (win_code_s != 2'd0) begin
                        win_r   <= win_code_s;
                        state_r <= ST_FIRE;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    feed_r        <= (win_r == 2'd1);
                    clean_r       <= (win_r == 2'd2);
                    play_r        <= (win_r == 2'd3);
                    last_action_r <= win_r;
                    cd_cnt_r      <= CD_LOAD;
                    state_r       <= ST_COOLDOWN;
                    busy_r        <= 1'b1;
                end
                ST_COOLDOWN: begin
                    // alive is deliberately ignored here: a started action always runs out.
                    if (cd_cnt_r == CD_ONE) begin
                        cd_cnt_r <= {CD_W{1'b0}};
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end else begin
                        cd_cnt_r <= cd_cnt_r - CD_W'(1);
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.feed        = feed_r;
    assign bus.play        = play_r;
    assign bus.clean_up    = clean_r;
    assign bus.busy        = busy_r;
    assign bus.rejected    = rejected_r;
    assign bus.last_action = last_action_r;
endmodule

// File: tb/tb_companion_action_ctrl.sv
// Bench for companion_action_ctrl: directed scenarios plus random button/alive/reset
// traffic, all checked every cycle against a history-based behavioural model.
module tb_companion_action_ctrl;
    localparam int DB = 4;
    localparam int CD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    companion_action_if bus();

    companion_action_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .COOLDOWN_CYCLES(CD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: raw button samples per edge (newest first), debounced view, and an
    // action engine expressed as "busy cycles remaining" plus a pending pulse code.
    bit [2:0] hist [$];
    bit [2:0] m_deb;
    bit [2:0] m_deb_prev;
    int       busy_left;
    int       fire_code;
    bit       m_feed, m_play, m_clean, m_busy, m_rej;
    bit [1:0] m_last;

    int c_feed, c_play, c_clean, c_rej, c_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int j = 0; j <= DB; j++) hist.push_back(3'b000);
        m_deb      = 3'b000;
        m_deb_prev = 3'b000;
        busy_left  = 0;
        fire_code  = 0;
        m_feed     = 1'b0;
        m_play     = 1'b0;
        m_clean    = 1'b0;
        m_busy     = 1'b0;
        m_rej      = 1'b0;
        m_last     = 2'd0;
    endtask

    task automatic model_edge();
        bit [2:0] raw;
        bit [2:0] req;
        bit [2:0] smp;
        bit       all_diff;
        int       n;
        raw = {bus.btn_play, bus.btn_clean, bus.btn_feed};
        if (!rst) begin
            model_reset();
            return;
        end
        req = m_deb & ~m_deb_prev;
        n   = $countones(req);
        m_feed  = (fire_code == 1);
        m_clean = (fire_code == 2);
        m_play  = (fire_code == 3);
        if (fire_code != 0) m_last = fire_code[1:0];
        fire_code = 0;
        if (busy_left == 0) begin
            if (bus.alive && n > 0) begin
                fire_code = req[0] ? 1 : (req[1] ? 2 : 3);
                busy_left = CD + 1;
                m_rej     = (n > 1);
            end else begin
                m_rej     = (n > 0);
            end
        end else begin
            m_rej = (n > 0);
            busy_left--;
        end
        m_busy = (busy_left > 0);
        // A button's debounced value flips once DB consecutive synchronized samples disagree with it.
        m_deb_prev = m_deb;
        for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DB; j++) begin
                smp = hist[j];
                if (smp[i] == m_deb[i]) all_diff = 1'b0;
            end
            if (all_diff) m_deb[i] = ~m_deb[i];
        end
        hist.push_front(raw);
        void'(hist.pop_back());
    endtask

    task automatic clr_counts();
        c_feed = 0; c_play = 0; c_clean = 0; c_rej = 0; c_busy = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("feed",        32'(bus.feed),        32'(m_feed));
        chk("play",        32'(bus.play),        32'(m_play));
        chk("clean_up",    32'(bus.clean_up),    32'(m_clean));
        chk("busy",        32'(bus.busy),        32'(m_busy));
        chk("rejected",    32'(bus.rejected),    32'(m_rej));
        chk("last_action", 32'(bus.last_action), 32'(m_last));
        if (bus.feed === 1'b1)     c_feed++;
        if (bus.play === 1'b1)     c_play++;
        if (bus.clean_up === 1'b1) c_clean++;
        if (bus.rejected === 1'b1) c_rej++;
        if (bus.busy === 1'b1)     c_busy++;
    endtask

    initial begin
        int pulse_edge;
        int k_idle;
        rst           = 1'b0;
        bus.btn_feed  = 1'b0;
        bus.btn_play  = 1'b0;
        bus.btn_clean = 1'b0;
        bus.alive     = 1'b1;
        model_reset();
        clr_counts();

        // Reset state
        repeat (2) tick();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_last", 32'(bus.last_action), 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Held feed: pulse after edge DB+3, busy for CD+1 cycles
        clr_counts();
        bus.btn_feed = 1'b1;
        pulse_edge = -1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (bus.feed === 1'b1 && pulse_edge < 0) pulse_edge = e;
        end
        chk("feed_latency", pulse_edge, 32'd7);
        chk("feed_once", c_feed, 32'd1);
        chk("busy_len", c_busy, 32'd9);
        chk("last_feed", 32'(bus.last_action), 32'd1);
        bus.btn_feed = 1'b0;
        repeat (15) tick();

        // Short glitch is filtered out
        clr_counts();
        bus.btn_feed = 1'b1;
        repeat (3) tick();
        bus.btn_feed = 1'b0;
        repeat (15) tick();
        chk("glitch_pulse", c_feed, 32'd0);
        chk("glitch_rej", c_rej, 32'd0);

        // Simultaneous clean + play: clean wins, play rejected
        clr_counts();
        bus.btn_play  = 1'b1;
        bus.btn_clean = 1'b1;
        repeat (25) tick();
        chk("simul_clean", c_clean, 32'd1);
        chk("simul_play", c_play, 32'd0);
        chk("simul_rej", c_rej, 32'd1);
        chk("simul_last", 32'(bus.last_action), 32'd2);
        bus.btn_play  = 1'b0;
        bus.btn_clean = 1'b0;
        repeat (20) tick();

        // Play request landing inside cooldown is dropped, cooldown length unchanged
        clr_counts();
        bus.btn_feed = 1'b1;
        pulse_edge = -1;
        for (int e = 0; e < 30 && pulse_edge < 0; e++) begin
            tick();
            if (bus.feed === 1'b1) pulse_edge = e;
        end
        chk("feed2_latency", pulse_edge, 32'd7);
        bus.btn_feed = 1'b0;
        bus.btn_play = 1'b1;
        k_idle = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.busy === 1'b0 && k_idle < 0) k_idle = k;
        end
        chk("cooldown_exit", k_idle, 32'd8);
        chk("cool_play", c_play, 32'd0);
        chk("cool_rej", c_rej, 32'd1);
        bus.btn_play = 1'b0;
        repeat (15) tick();

        // Dead companion: request dropped
        clr_counts();
        bus.alive    = 1'b0;
        bus.btn_feed = 1'b1;
        repeat (15) tick();
        chk("dead_pulse", c_feed, 32'd0);
        chk("dead_busy", c_busy, 32'd0);
        chk("dead_rej", c_rej, 32'd1);
        chk("dead_last", 32'(bus.last_action), 32'd1);
        bus.btn_feed = 1'b0;
        repeat (12) tick();
        bus.alive = 1'b1;
        repeat (3) tick();

        // Reset during cooldown with feed still held
        clr_counts();
        bus.btn_feed = 1'b1;
        pulse_edge = -1;
        for (int e = 0; e < 30 && pulse_edge < 0; e++) begin
            tick();
            if (bus.feed === 1'b1) pulse_edge = e;
        end
        chk("feed3_latency", pulse_edge, 32'd7);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_feed", 32'(bus.feed), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rej", 32'(bus.rejected), 32'd0);
        chk("rst_last", 32'(bus.last_action), 32'd0);
        rst = 1'b1;
        pulse_edge = -1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (bus.feed === 1'b1 && pulse_edge < 0) pulse_edge = e;
        end
        chk("post_reset_latency", pulse_edge, 32'd7);
        bus.btn_feed = 1'b0;
        repeat (20) tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(9) == 0) bus.btn_feed  = ~bus.btn_feed;
            if ($urandom_range(9) == 0) bus.btn_clean = ~bus.btn_clean;
            if ($urandom_range(9) == 0) bus.btn_play  = ~bus.btn_play;
            if ($urandom_range(60) == 0) bus.alive    = ~bus.alive;
            rst = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
